// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
//   Shared types and helpers for the data-side memory bridge.
//   - state_t      : bridge FSM states (IDLE, REQ, WAIT_RSP, DONE)
//   - SIZE_B/H/W   : MEM-stage size masks (byte, half, word)
//   - size_kind_t  : decoded access width; undefined masks decode as word
//   - lane_*       : byte-enable generation, store replication, load
//                    extraction and misalignment detection
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_kind_t;

    function automatic size_kind_t decode_size(input logic [3:0] size);
        case (size)
            SIZE_B:  return SZ_BYTE;
            SIZE_H:  return SZ_HALF;
            SIZE_W:  return SZ_WORD;
            default: return SZ_WORD;  // unknown masks behave as a full word
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input size_kind_t kind, input logic [1:0] off);
        case (kind)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input size_kind_t kind, input logic [31:0] wdata);
        case (kind)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input size_kind_t kind, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        case (kind)
            SZ_BYTE: begin
                case (off)
                    2'd0:    return {24'b0, rdata[7:0]};
                    2'd1:    return {24'b0, rdata[15:8]};
                    2'd2:    return {24'b0, rdata[23:16]};
                    default: return {24'b0, rdata[31:24]};
                endcase
            end
            SZ_HALF: return off[1] ? {16'b0, rdata[31:16]} : {16'b0, rdata[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic lane_misaligned(input size_kind_t kind, input logic [1:0] off);
        return ((kind == SZ_HALF) && off[0]) || ((kind == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align (combinational)
//   Byte-lane alignment between the MEM stage and a 32-bit data bus.
//   Optional feature macro: MISALIGN_TRAP_EN (flags misaligned half/word).
//   Ports:
//     addr_lo_i  [1:0]  byte offset within the word
//     size_i     [3:0]  size mask (0001 byte, 0011 half, else word)
//     wdata_i    [31:0] right-justified store data
//     rdata_i    [31:0] raw bus read word
//     be_o       [3:0]  byte enables
//     wdata_o    [31:0] lane-replicated store data
//     rdata_o    [31:0] right-justified, zero-filled load data
//     misalign_o        access violates its natural alignment
// -----------------------------------------------------------------------------
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [3:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    size_kind_t kind;

    assign kind    = decode_size(size_i);
    assign be_o    = lane_be(kind, addr_lo_i);
    assign wdata_o = lane_wdata(kind, wdata_i);
    assign rdata_o = lane_extract(kind, addr_lo_i, rdata_i);

`ifdef MISALIGN_TRAP_EN
    assign misalign_o = lane_misaligned(kind, addr_lo_i);
`else
    // Sub-size low address bits are simply ignored, so nothing is misaligned.
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//   Data-side bridge between the MEM stage and a wait-state data memory.
//   Aligns byte lanes, runs the req/gnt/rvalid handshake and stalls the
//   pipeline until the access completes. Optional feature macro:
//   MISALIGN_TRAP_EN (misaligned half/word accesses skip the bus and flag
//   o_misalign in the DONE cycle).
//   Parameter TIMEOUT_CYCLES: cycles allowed in REQ/WAIT_RSP before a bus
//   error (0 disables the timeout).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     i_ma_addr/wdata/size     MEM-stage access
//     i_ma_rd_en/wr_en         load / store request (both high = store)
//     o_rdata                  right-justified load data (valid in DONE)
//     o_stall                  pipeline stall
//     o_misalign, o_bus_err    one-cycle flags in the DONE cycle
//     o_bus_req/we/addr/be/wdata  bus request side
//     i_bus_gnt, i_bus_rvalid, i_bus_rdata  bus grant / response
// -----------------------------------------------------------------------------
module data_mem_bridge
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_ma_addr,
    input  logic [31:0] i_ma_wdata,
    input  logic [3:0]  i_ma_size,
    input  logic        i_ma_rd_en,
    input  logic        i_ma_wr_en,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned   CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic        acc;
    logic        is_wr;
    logic [3:0]  lane_be_w;
    logic [31:0] lane_wdata_w;
    logic [31:0] lane_rdata_w;
    logic        misalign_hit;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      hold_q, hold_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;
    logic             req;
    logic             timeout_hit;

    assign acc   = i_ma_rd_en | i_ma_wr_en;
    assign is_wr = i_ma_wr_en;  // a simultaneous read request is dropped

    mem_lane_align u_align (
        .addr_lo_i  (i_ma_addr[1:0]),
        .size_i     (i_ma_size),
        .wdata_i    (i_ma_wdata),
        .rdata_i    (i_bus_rdata),
        .be_o       (lane_be_w),
        .wdata_o    (lane_wdata_w),
        .rdata_o    (lane_rdata_w),
        .misalign_o (misalign_hit)
    );

    // cnt_inc is the number of cycles spent in REQ/WAIT_RSP including this one.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        req     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    hold_d = '0;
                    cnt_d  = '0;
                    if (misalign_hit) begin
                        mis_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        req = 1'b1;
                        if (i_bus_gnt) state_d = is_wr ? ST_DONE : ST_WAIT_RSP;
                        else           state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                req   = 1'b1;
                cnt_d = cnt_inc;
                // A grant in the final allowed cycle still wins over the timeout.
                if (i_bus_gnt) begin
                    cnt_d   = '0;
                    state_d = is_wr ? ST_DONE : ST_WAIT_RSP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_DONE;
                end
            end

            ST_WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (i_bus_rvalid) begin
                    hold_d  = lane_rdata_w;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the hold register is reset too because o_rdata exposes it
            // and must read as zero out of reset.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Request and stall are combinational from the IDLE state, so they are
    // masked while reset is held to keep the bus quiet during a flush.
    assign o_bus_req   = req & ~rst;
    assign o_bus_we    = o_bus_req & is_wr;
    assign o_bus_be    = o_bus_req ? lane_be_w : 4'b0000;
    assign o_bus_addr  = {i_ma_addr[31:2], 2'b00};
    assign o_bus_wdata = lane_wdata_w;

    assign o_stall    = acc & (state_q != ST_DONE) & ~rst;
    assign o_rdata    = (state_q == ST_DONE) ? hold_q : 32'h0;
    assign o_misalign = mis_q;
    assign o_bus_err  = err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge (TIMEOUT_CYCLES = 4).
// Cycle index c counts from the cycle the access is presented (c = 0);
// the responder grants at c = g and returns read data at c = g + r.
module tb_data_mem_bridge;

    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ma_addr, ma_wdata;
    logic [3:0]  ma_size;
    logic        ma_rd_en, ma_wr_en;
    logic [31:0] o_rdata;
    logic        o_stall, o_misalign, o_bus_err, o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ma_addr    (ma_addr),
        .i_ma_wdata   (ma_wdata),
        .i_ma_size    (ma_size),
        .i_ma_rd_en   (ma_rd_en),
        .i_ma_wr_en   (ma_wr_en),
        .o_rdata      (o_rdata),
        .o_stall      (o_stall),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_gnt    (bus_gnt),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  size;
        logic        rd;
        logic        wr;
        int          g;
        int          r;
        logic [31:0] bus_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          done;
        logic        exp_err;
        logic        exp_mis;
    } vec_t;

    // Reference model: outcome of one access from the access rules alone.
    function automatic vec_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] size, input logic rd, input logic wr,
                                   input int g, input int r, input logic [31:0] brd);
        vec_t v;
        int   nbytes;
        int   off;
        logic mis;
        off    = int'(addr % 4);
        nbytes = (size == 4'b0001) ? 1 : (size == 4'b0011) ? 2 : 4;
        mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis    = (off % nbytes) != 0;
`endif
        v.addr = addr; v.wdata = wdata; v.size = size; v.rd = rd; v.wr = wr;
        v.g = mis ? NEVER : g;
        v.r = (mis || wr) ? NEVER : r;
        v.bus_rdata = brd;
        v.exp_be    = (nbytes == 1) ? 4'(1 << off) : (nbytes == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
        v.exp_wdata = (nbytes == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                      (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        if (wr || mis)        v.exp_rdata = 32'h0;
        else if (nbytes == 1) v.exp_rdata = (brd >> (8 * off)) & 32'hFF;
        else if (nbytes == 2) v.exp_rdata = (brd >> (16 * (off / 2))) & 32'hFFFF;
        else                  v.exp_rdata = brd;
        v.done    = mis ? 1 : wr ? g + 1 : g + r + 1;
        v.exp_err = 1'b0;
        v.exp_mis = mis;
        return v;
    endfunction

    task automatic run_access(input int idx, input vec_t v);
        logic  exp_req;
        string p;
        for (int c = 0; c <= v.done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                ma_addr = v.addr; ma_wdata = v.wdata; ma_size = v.size;
                ma_rd_en = v.rd;  ma_wr_en = v.wr;
            end
            bus_gnt    = (c == v.g);
            bus_rvalid = (v.r != NEVER) && (c == v.g + v.r);
            bus_rdata  = v.bus_rdata;
            #1;
            p       = $sformatf("v%0d c%0d", idx, c);
            exp_req = !v.exp_mis && (c <= v.g) && (c < v.done);
            check({p, " stall"}, 32'(o_stall), 32'(c < v.done));
            check({p, " req"}, 32'(o_bus_req), 32'(exp_req));
            if (exp_req) begin
                check({p, " addr"}, o_bus_addr, v.addr & 32'hFFFF_FFFC);
                check({p, " be"}, 32'(o_bus_be), 32'(v.exp_be));
                check({p, " we"}, 32'(o_bus_we), 32'(v.wr));
                if (v.wr) check({p, " wdata"}, o_bus_wdata, v.exp_wdata);
            end
            check({p, " rdata"}, o_rdata, (c == v.done) ? v.exp_rdata : 32'h0);
            check({p, " err"}, 32'(o_bus_err), 32'((c == v.done) && v.exp_err));
            check({p, " misalign"}, 32'(o_misalign), 32'((c == v.done) && v.exp_mis));
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        ma_rd_en = 1'b0; ma_wr_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        check({tag, " idle stall"}, 32'(o_stall), 32'h0);
        check({tag, " idle req"}, 32'(o_bus_req), 32'h0);
        check({tag, " idle rdata"}, o_rdata, 32'h0);
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, want $finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        vec_t v;
        int   ty, sel;
        logic [3:0] sz;

        rst = 1'b1;
        ma_addr = '0; ma_wdata = '0; ma_size = '0; ma_rd_en = 1'b0; ma_wr_en = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        repeat (2) @(posedge clk);
        #2;
        check("reset stall", 32'(o_stall), 32'h0);
        check("reset req", 32'(o_bus_req), 32'h0);
        check("reset we", 32'(o_bus_we), 32'h0);
        check("reset misalign", 32'(o_misalign), 32'h0);
        check("reset err", 32'(o_bus_err), 32'h0);
        check("reset rdata", o_rdata, 32'h0);
        check("reset be", 32'(o_bus_be), 32'h0);
        @(negedge clk) rst = 1'b0;
        idle_cycle("post-reset");

        // Directed vectors with hand-computed expectations.
        vecs[0] = '{addr:32'h103, wdata:32'h0, size:4'b0001, rd:1, wr:0, g:0, r:1,
                    bus_rdata:32'hAABB_CCDD, exp_be:4'h8, exp_wdata:32'h0,
                    exp_rdata:32'h0000_00AA, done:2, exp_err:0, exp_mis:0};
        vecs[1] = '{addr:32'h202, wdata:32'h1234, size:4'b0011, rd:0, wr:1, g:3, r:NEVER,
                    bus_rdata:32'h0, exp_be:4'hC, exp_wdata:32'h1234_1234,
                    exp_rdata:32'h0, done:4, exp_err:0, exp_mis:0};
        vecs[2] = '{addr:32'h300, wdata:32'h0, size:4'b1111, rd:1, wr:0, g:0, r:NEVER,
                    bus_rdata:32'h7777_7777, exp_be:4'hF, exp_wdata:32'h0,
                    exp_rdata:32'h0, done:5, exp_err:1, exp_mis:0};
`ifdef MISALIGN_TRAP_EN
        vecs[3] = '{addr:32'h101, wdata:32'h0, size:4'b1111, rd:1, wr:0, g:NEVER, r:NEVER,
                    bus_rdata:32'h1122_3344, exp_be:4'hF, exp_wdata:32'h0,
                    exp_rdata:32'h0, done:1, exp_err:0, exp_mis:1};
        vecs[8] = '{addr:32'h203, wdata:32'h0, size:4'b0011, rd:1, wr:0, g:NEVER, r:NEVER,
                    bus_rdata:32'h1234_5678, exp_be:4'hC, exp_wdata:32'h0,
                    exp_rdata:32'h0, done:1, exp_err:0, exp_mis:1};
`else
        vecs[3] = '{addr:32'h101, wdata:32'h0, size:4'b1111, rd:1, wr:0, g:1, r:2,
                    bus_rdata:32'h1122_3344, exp_be:4'hF, exp_wdata:32'h0,
                    exp_rdata:32'h1122_3344, done:4, exp_err:0, exp_mis:0};
        vecs[8] = '{addr:32'h203, wdata:32'h0, size:4'b0011, rd:1, wr:0, g:0, r:1,
                    bus_rdata:32'h1234_5678, exp_be:4'hC, exp_wdata:32'h0,
                    exp_rdata:32'h0000_1234, done:2, exp_err:0, exp_mis:0};
`endif
        vecs[4] = '{addr:32'h10, wdata:32'hCAFE_F00D, size:4'b1111, rd:1, wr:1, g:0, r:1,
                    bus_rdata:32'h5555_5555, exp_be:4'hF, exp_wdata:32'hCAFE_F00D,
                    exp_rdata:32'h0, done:1, exp_err:0, exp_mis:0};
        vecs[5] = '{addr:32'h2, wdata:32'h0, size:4'b0011, rd:1, wr:0, g:2, r:3,
                    bus_rdata:32'h89AB_CDEF, exp_be:4'hC, exp_wdata:32'h0,
                    exp_rdata:32'h0000_89AB, done:6, exp_err:0, exp_mis:0};
        vecs[6] = '{addr:32'h1, wdata:32'hFFFF_FF5A, size:4'b0001, rd:0, wr:1, g:0, r:NEVER,
                    bus_rdata:32'h0, exp_be:4'h2, exp_wdata:32'h5A5A_5A5A,
                    exp_rdata:32'h0, done:1, exp_err:0, exp_mis:0};
        vecs[7] = '{addr:32'h8, wdata:32'h0, size:4'b0101, rd:1, wr:0, g:0, r:2,
                    bus_rdata:32'h0BAD_F00D, exp_be:4'hF, exp_wdata:32'h0,
                    exp_rdata:32'h0BAD_F00D, done:3, exp_err:0, exp_mis:0};

        for (int i = 0; i < 9; i++) run_access(i, vecs[i]);
        idle_cycle("directed");

        // Reset during WAIT_RSP, late response after release must be dropped.
        @(posedge clk); #1;
        ma_addr = 32'h40; ma_size = 4'b1111; ma_rd_en = 1'b1; ma_wr_en = 1'b0; bus_gnt = 1'b1;
        #1;
        check("rst-seq req", 32'(o_bus_req), 32'h1);
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #1;
        check("rst-seq wait stall", 32'(o_stall), 32'h1);
        check("rst-seq wait req", 32'(o_bus_req), 32'h0);
        rst = 1'b1; ma_rd_en = 1'b0;
        #1;
        check("rst-seq in-reset req", 32'(o_bus_req), 32'h0);
        check("rst-seq in-reset stall", 32'(o_stall), 32'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst-seq late rvalid stall", 32'(o_stall), 32'h0);
        check("rst-seq late rvalid rdata", o_rdata, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        #1;
        check("rst-seq after rdata", o_rdata, 32'h0);
        check("rst-seq after err", 32'(o_bus_err), 32'h0);
        run_access(100, model(32'h41, 32'h0, 4'b0001, 1'b1, 1'b0, 0, 1, 32'h0102_0304));

        // Randomized accesses against the model.
        for (int i = 0; i < 200; i++) begin
            ty  = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            sz  = (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0011 : (sel == 2) ? 4'b1111 : 4'($urandom);
            v = model($urandom, $urandom, sz, ty != 1, ty != 0,
                      $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            run_access(1000 + i, v);
            if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Data-side bus bridge between the MEM pipeline stage and data memory. It takes the stage's raw access (address, store data, size mask, read/write enables) and performs byte-lane alignment, generating byte enables for stores and right-justifying load data. It runs a request/grant/response handshake with a wait-state memory and stalls the pipeline until the access completes. Its read data feeds the MEM stage's data-read input; its stall output gates the pipeline clock enable.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT_RSP before aborting with a bus error; 0 disables the timeout.

Ports (clk and rst as the codebase names them: `clk`; reset `rst`, asynchronous, active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_ma_addr  in  32  byte address from MEM stage
- i_ma_wdata  in  32  store data, right-justified
- i_ma_size  in  4  size mask: 0001=byte, 0011=half, 1111=word; any other value is treated as word
- i_ma_rd_en  in  1  load request
- i_ma_wr_en  in  1  store request
- o_rdata  out  32  load data, right-justified, zero-filled above size (MEM stage does sign/zero extension)
- o_stall  out  1  pipeline stall (pipeline clk_en = ~o_stall)
- o_misalign  out  1  one-cycle misaligned-access flag
- o_bus_err  out  1  one-cycle timeout flag
- o_bus_req, o_bus_we  out  1  bus request, write strobe
- o_bus_addr  out  32  word address ({addr[31:2],2'b00})
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_gnt  in  1  request accepted
- i_bus_rvalid  in  1  read response valid
- i_bus_rdata  in  32  read response word

## Operation
- Access valid: `acc = i_ma_rd_en | i_ma_wr_en`. If both enables are high, the access is treated as a write and o_rdata is 0.
- Store lanes:
  - byte: wdata = {4{wdata[7:0]}}, be = 0001 << addr[1:0]
  - half: wdata = {2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011
  - word: wdata unchanged, be = 1111
- Loads: the bus be is set as for a store. Extraction:
  - byte: o_rdata = {24'b0, rdata >> 8*addr[1:0]}[7:0]
  - half: upper or lower half selected by addr[1]
  - word: unchanged
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE: when acc, o_bus_req is asserted combinationally in the same cycle. On gnt, go to WAIT_RSP (read) or DONE (write). With no gnt, go to REQ.
  - REQ: hold req, addr, be, wdata and we stable until gnt, then transition as from IDLE.
  - WAIT_RSP: on rvalid, capture the aligned data into the hold register and go to DONE.
  - DONE: o_stall=0 for exactly one cycle, o_rdata driven from the hold register, next state IDLE.
- o_stall = acc & (state != DONE).
- Timeout: the counter clears on entry to REQ/WAIT_RSP and increments each cycle there. When it reaches TIMEOUT_CYCLES, go to DONE with o_bus_err=1, hold register = 0, and o_bus_req dropped.
- An i_bus_rvalid arriving in IDLE, REQ or DONE is ignored.

## Timing
- Reset values: state=IDLE, hold register=0, counter=0. All outputs are 0: o_stall, o_bus_req, o_bus_we, o_misalign, o_bus_err, o_rdata, o_bus_be.
- Best-case read: req and gnt in cycle T, rvalid at T+1, DONE at T+2. Stall is high in T and T+1.
- Best-case write: gnt at T, DONE at T+1. Stall is high in T only.
- With no access, o_stall=0 and there is no added latency.
- Reset mid-access: return to IDLE immediately and drop req; a late rvalid is discarded.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are a half with addr[0]=1, or a word with addr[1:0]≠0.
  - A misaligned access issues no bus request and goes IDLE→DONE directly, with o_misalign=1 in the DONE cycle and o_rdata=0.
- Undefined:
  - o_misalign is tied to 0.
  - The low address bits beyond the size are ignored: a half uses addr[1], a word uses the aligned word.

## Structure
- Package riscv_mem_pkg holds:
  - the FSM state enum
  - the size-mask constants SIZE_B/SIZE_H/SIZE_W
  - the lane-replication/byte-enable function prototypes
- Sub-module mem_lane_align (combinational): computes be, store replication and load extraction from addr[1:0] and size. The FSM, timeout counter and hold register live in data_mem_bridge.

## Test plan
- LB at 0x103, bus returns 0xAABBCCDD with gnt in T and rvalid at T+1 → o_rdata=0x000000AA at T+2; stall high for 2 cycles.
- SH 0x1234 at 0x202 with gnt delayed 3 cycles → o_bus_be=1100 and o_bus_wdata=0x12341234, held stable for 4 cycles; DONE on the following cycle.
- LW with no rvalid, TIMEOUT_CYCLES=4 → o_bus_err pulse, o_rdata=0, req deasserted.
- LW at 0x101 with MISALIGN_TRAP_EN → no o_bus_req, o_misalign one cycle, o_stall=0 that cycle. Without the macro → bus addr 0x100, be=1111.
- Reset asserted during WAIT_RSP, rvalid arriving one cycle after release → state IDLE, response ignored, o_rdata=0.
- rd_en and wr_en both high → o_bus_we=1, o_rdata=0.
